// File: rtl/prach_hb1_sched.sv
// PRACH HB1 front-end sequencer: splits a channel-interleaved TDM stream into per-channel even/odd pairs.
// Optional statistics ports (err_cnt, frame_cnt) are enabled with `define PRACH_HB1_SCHED_STATS_EN.
module prach_hb1_sched #(
    parameter int unsigned NUM_CHANNEL = 16,
    parameter int unsigned DW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          sync_in,
    output logic [DW-1:0] dout_dp1,
    output logic [DW-1:0] dout_dp2,
    output logic [7:0]    dout_chn,
    output logic          dout_valid,
    output logic          sync_out,
    output logic          locked,
    output logic          sync_err
`ifdef PRACH_HB1_SCHED_STATS_EN
    ,
    output logic [15:0]   err_cnt,
    output logic [31:0]   frame_cnt
`endif
);

    localparam int unsigned CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNEL - 1);

    typedef enum logic [1:0] {ALIGN, EVEN, ODD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] pair_buf [NUM_CHANNEL];

    logic          sync_ok;
    logic          ch0_entry;
    logic          buf_we;
    logic [CW-1:0] buf_waddr;

    // A sync seen in ALIGN, or a misplaced sync while tracking, both start a new frame as ch0 even.
    assign sync_ok   = (sync_in == (cnt == '0));
    assign ch0_entry = din_valid && sync_in && ((state == ALIGN) || !sync_ok);
    assign buf_we    = ch0_entry || (din_valid && (state == EVEN) && sync_ok);
    assign buf_waddr = ch0_entry ? '0 : cnt;

    // Even-phase buffer; contents are never reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pair_buf[buf_waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALIGN;
            cnt        <= '0;
            dout_dp1   <= '0;
            dout_dp2   <= '0;
            dout_chn   <= '0;
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                case (state)
                    ALIGN: begin
                        if (sync_in) begin
                            cnt    <= CW'(1);
                            state  <= EVEN;
                            locked <= 1'b1;
                        end
                    end
                    default: begin
                        if (!sync_ok) begin
                            sync_err <= 1'b1;
                            // A misplaced sync realigns on the spot; a missing one falls back to search.
                            if (sync_in) begin
                                cnt    <= CW'(1);
                                state  <= EVEN;
                                locked <= 1'b1;
                            end else begin
                                cnt    <= '0;
                                state  <= ALIGN;
                                locked <= 1'b0;
                            end
                        end else begin
                            if (state == ODD) begin
                                dout_valid <= 1'b1;
                                dout_dp1   <= din;
                                dout_dp2   <= pair_buf[cnt];
                                dout_chn   <= 8'(cnt);
                                sync_out   <= (cnt == '0);
                            end
                            cnt <= cnt + CW'(1);
                            if (cnt == LAST_CH) begin
                                state <= (state == EVEN) ? ODD : EVEN;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef PRACH_HB1_SCHED_STATS_EN
    // Saturating sync-error count and wrapping count of completed odd frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else if (din_valid && (state != ALIGN)) begin
            if (!sync_ok) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'(1);
                end
            end else if ((state == ODD) && (cnt == LAST_CH)) begin
                frame_cnt <= frame_cnt + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_prach_hb1_sched.sv
// Self-checking bench for prach_hb1_sched: scenario tasks push expected pairs, a monitor pops and compares.
module tb_prach_hb1_sched;

    localparam int unsigned NCH = 16;
    localparam int unsigned DW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          sync_in;
    logic [DW-1:0] dout_dp1;
    logic [DW-1:0] dout_dp2;
    logic [7:0]    dout_chn;
    logic          dout_valid;
    logic          sync_out;
    logic          locked;
    logic          sync_err;
`ifdef PRACH_HB1_SCHED_STATS_EN
    logic [15:0]   err_cnt;
    logic [31:0]   frame_cnt;
`endif

    prach_hb1_sched #(.NUM_CHANNEL(NCH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync_in    (sync_in),
        .dout_dp1   (dout_dp1),
        .dout_dp2   (dout_dp2),
        .dout_chn   (dout_chn),
        .dout_valid (dout_valid),
        .sync_out   (sync_out),
        .locked     (locked),
        .sync_err   (sync_err)
`ifdef PRACH_HB1_SCHED_STATS_EN
        ,
        .err_cnt    (err_cnt),
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  chn;
        logic [15:0] dp1;
        logic [15:0] dp2;
        logic        so;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every emitted pair must match the oldest expectation, including the cycle it appears in.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pair got chn=%0d dp1=%0d dp2=%0d cyc=%0d, want no pair",
                             dout_chn, dout_dp1, dout_dp2, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (dout_chn !== e.chn || dout_dp1 !== e.dp1 || dout_dp2 !== e.dp2 ||
                        sync_out !== e.so || cyc !== e.cyc) begin
                        bad++;
                        $display("FAIL pair got chn=%0d dp1=%0d dp2=%0d sync=%0b cyc=%0d want chn=%0d dp1=%0d dp2=%0d sync=%0b cyc=%0d",
                                 dout_chn, dout_dp1, dout_dp2, sync_out, cyc,
                                 e.chn, e.dp1, e.dp2, e.so, e.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic s);
        din       = 16'(d);
        sync_in   = s;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        sync_in   = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        sync_in   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int k, input int p1, input int p2);
        exp_t e;
        e.chn = 8'(k);
        e.dp1 = 16'(p1);
        e.dp2 = 16'(p2);
        e.so  = (k == 0);
        e.cyc = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        din       = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        idle(3);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d want 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (dout_valid !== 1'b0 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got valid=%0b sync_out=%0b want 0 0", dout_valid, sync_out);
        end
        total++;
        if (locked !== 1'b0 || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got locked=%0b sync_err=%0b want 0 0", locked, sync_err);
        end
        total++;
        if (dout_dp1 !== 16'd0 || dout_dp2 !== 16'd0 || dout_chn !== 8'd0) begin
            bad++;
            $display("FAIL reset_data got dp1=%0d dp2=%0d chn=%0d want 0 0 0", dout_dp1, dout_dp2, dout_chn);
        end
`ifdef PRACH_HB1_SCHED_STATS_EN
        total++;
        if (err_cnt !== 16'd0 || frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_stats got err=%0d frames=%0d want 0 0", err_cnt, frame_cnt);
        end
`endif
    endtask

    task automatic test_dense();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            if (i >= 16 && i < 32) push(i - 16, i, i - 16);
            send(i, (i % 16) == 0);
            if (i == 0) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL dense_lock got locked=%0b want 1", locked);
                end
            end
        end
        check_drained("dense");
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            if (i >= 16 && i < 32) push(i - 16, i, i - 16);
            send(i, (i % 16) == 0);
            idle(1);
        end
        check_drained("gaps");
    endtask

    task automatic test_late_start();
        do_reset();
        for (int i = 5; i < 16; i++) send(i, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL late_prelock got locked=%0b want 0", locked);
        end
        for (int i = 16; i < 48; i++) begin
            if (i >= 32) push(i - 32, i, i - 16);
            send(i, (i % 16) == 0);
            if (i == 16) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL late_lock got locked=%0b want 1", locked);
                end
            end
        end
        check_drained("late");
    endtask

    task automatic test_extra_sync();
        do_reset();
        for (int i = 0; i < 16; i++) send(i, i == 0);
        for (int k = 0; k < 7; k++) begin
            push(k, 16 + k, k);
            send(16 + k, k == 0);
        end
        send(23, 1'b1);
        total++;
        if (sync_err !== 1'b1) begin
            bad++;
            $display("FAIL extra_err got sync_err=%0b want 1", sync_err);
        end
        for (int k = 1; k < 16; k++) begin
            send(200 + k, 1'b0);
            if (k == 1) begin
                total++;
                if (sync_err !== 1'b0) begin
                    bad++;
                    $display("FAIL extra_pulse got sync_err=%0b want 0", sync_err);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            push(k, 300 + k, (k == 0) ? 23 : 200 + k);
            send(300 + k, k == 0);
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL extra_relock got locked=%0b want 1", locked);
        end
        check_drained("extra");
    endtask

    task automatic test_missing_sync();
        do_reset();
        for (int i = 0; i < 16; i++) send(i, i == 0);
        send(16, 1'b0);
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL miss_err got sync_err=%0b locked=%0b want 1 0", sync_err, locked);
        end
        send(17, 1'b0);
        send(18, 1'b0);
        total++;
        if (sync_err !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL miss_align got sync_err=%0b locked=%0b want 0 0", sync_err, locked);
        end
        for (int i = 0; i < 32; i++) begin
            if (i >= 16) push(i - 16, 500 + i, 500 + i - 16);
            send(500 + i, (i % 16) == 0);
            if (i == 0) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL miss_relock got locked=%0b want 1", locked);
                end
            end
        end
        check_drained("miss");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 16; i++) send(i, i == 0);
        for (int k = 0; k < 9; k++) begin
            push(k, 16 + k, k);
            send(16 + k, k == 0);
        end
        rst       = 1'b1;
        din       = 16'd25;
        sync_in   = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        total++;
        if (dout_valid !== 1'b0 || dout_dp1 !== 16'd0 || dout_dp2 !== 16'd0 ||
            dout_chn !== 8'd0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL midrst_out got valid=%0b dp1=%0d dp2=%0d chn=%0d locked=%0b want all 0",
                     dout_valid, dout_dp1, dout_dp2, dout_chn, locked);
        end
        for (int i = 26; i < 32; i++) send(i, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL midrst_lock got locked=%0b want 0", locked);
        end
        check_drained("midrst");
    endtask

`ifdef PRACH_HB1_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        send(1000, 1'b1);
        send(1001, 1'b1);
        send(1002, 1'b1);
        send(1003, 1'b1);
        total++;
        if (err_cnt !== 16'd3 || frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stats_err got err=%0d frames=%0d want 3 0", err_cnt, frame_cnt);
        end
        for (int k = 1; k < 16; k++) send(1100 + k, 1'b0);
        for (int k = 0; k < 16; k++) begin
            push(k, 1200 + k, (k == 0) ? 1003 : 1100 + k);
            send(1200 + k, k == 0);
        end
        total++;
        if (err_cnt !== 16'd3 || frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL stats_frame got err=%0d frames=%0d want 3 1", err_cnt, frame_cnt);
        end
        check_drained("stats");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        din       = '0;
        @(negedge clk);
        test_reset();
        test_dense();
        test_gaps();
        test_late_start();
        test_extra_sync();
        test_missing_sync();
        test_reset_mid();
`ifdef PRACH_HB1_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prach_hb1_sched.md
Name: prach_hb1_sched

Overview:
Front-end sequencer for the 16-channel PRACH half-band decimator stage.
- Takes a channel-interleaved TDM sample stream (one sample per valid cycle, channel 0 flagged by sync) and splits it into even/odd polyphase pairs per channel.
- Emits one channel-indexed pair per odd-frame input, with channel number and frame sync, directly feeding the HB1 channel datapath's dp1/dp2/chn/sync inputs.
- Tracks frame alignment, recovers from sync errors and reports lock status.

Parameters:
NUM_CHANNEL, 16, channels per TDM frame; power of two, 2..256.
DW, 16, sample width in bits.

Ports:
clk  input  1  processing clock
rst  input  1  synchronous reset, active-high
din  input  DW  TDM input sample
din_valid  input  1  din qualifier
sync_in  input  1  marks channel 0 sample of a frame; meaningful only with din_valid
dout_dp1  output  DW  odd-phase sample (center-tap branch)
dout_dp2  output  DW  even-phase sample (FIR branch)
dout_chn  output  8  channel index of emitted pair
dout_valid  output  1  pair qualifier
sync_out  output  1  high with dout_valid when dout_chn == 0
locked  output  1  high while frame-aligned
sync_err  output  1  one-cycle pulse on detected misalignment

Behaviour:
- Single clock; rst synchronous, active-high. On reset:
  - all outputs 0;
  - state ALIGN;
  - channel counter cnt = 0;
  - even buffer contents don't-care.
- Only cycles with din_valid = 1 advance state or counters. din_valid = 0 cycles are ignored, with gaps of any length allowed.
- States:
  - ALIGN: discard samples until din_valid && sync_in. That sample is ch0 even: store into buf[0], cnt = 1, go EVEN, locked = 1.
  - EVEN: store din into buf[cnt].
  - ODD: emit the pair {dp1 = din, dp2 = buf[cnt]}.
  - EVEN and ODD each cover one full frame. On a valid sample with cnt == NUM_CHANNEL-1, cnt wraps to 0 and the state toggles EVEN <-> ODD.
- Sync check, applied on every valid sample in EVEN/ODD:
  - expected: sync_in == (cnt == 0);
  - mismatch: sync_err pulses for 1 cycle, locked drops, and the partial frame is abandoned with no further pairs from it;
  - if the mismatching sample has sync_in = 1, it is taken immediately as ch0 even (same as the ALIGN entry);
  - otherwise go to ALIGN.
- Output timing: all outputs are registered, 1 cycle after the ODD-state valid input.
  - dout_valid = 1; dout_chn = cnt zero-extended to 8 bits; sync_out = (cnt == 0).
  - dout_dp1/dp2 hold their last values when dout_valid = 0.
- Throughput: NUM_CHANNEL pairs per 2*NUM_CHANNEL valid inputs. Output is bursty: in a fully dense input, valid for one frame and idle for the next.
- No backpressure; the downstream always accepts.
- Buffer: NUM_CHANNEL x DW storage (mlab/distributed RAM permitted). Write in EVEN and read in ODD occur in different frames, so there is no read/write collision.
- Reset mid-frame: everything restarts in ALIGN, and no pair is emitted from pre-reset data.
- rst takes priority over all inputs in the same cycle.

Optional Feature:
Macro PRACH_HB1_SCHED_STATS_EN.
- Defined:
  - adds output err_cnt [15:0], counting sync_err pulses and saturating at 0xFFFF (cleared by rst);
  - adds output frame_cnt [31:0], incrementing on each completed ODD frame and wrapping (cleared by rst).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then dense input, din = 16-bit sample index (0,1,2,...), sync_in on every 16th sample starting at 0 -> locked = 1 after first sync. First pairs at input 16..31: dout_chn = k, dp2 = k, dp1 = 16+k, each 1 cycle after input. sync_out only with chn 0. No dout_valid during inputs 32..47.
- Same stream with din_valid toggling 1,0,1,0 -> identical pair sequence and values; dout_valid only in the cycle after a valid odd-frame input.
- Stream starting at channel 5 (no sync for 11 samples) -> no output, locked = 0 until the first sync. The first pair is from the frame pair after that sync.
- Extra sync_in at cnt = 7 in an ODD frame -> sync_err pulse, pairs 0..6 emitted and none for 7..15. That sample is treated as ch0 even, so the next odd frame emits chn 0..15 correctly.
- Missing sync at cnt = 0 -> sync_err, state ALIGN, locked = 0, relock on the next sync.
- rst asserted mid-ODD frame (chn 9) -> outputs 0 next cycle, no stale pair after release. With PRACH_HB1_SCHED_STATS_EN: err_cnt = 0 after reset; 3 injected errors give err_cnt = 3; frame_cnt counts completed odd frames.
